// File: rtl/variable_table_readback_pkg.sv
// Shared types and constants for the variable table readback engine.
package variable_table_readback_pkg;

  localparam int unsigned DEF_VARIABLE_ADDRESS_WIDTH = 11;
  localparam int unsigned DEF_WORD_WIDTH             = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OUT,
    FIN
  } state_t;

  // Number of output words needed for n variables packed w bits per word.
  function automatic int unsigned word_count(input int unsigned n, input int unsigned w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/variable_table_readback_packer.sv
// Bit-to-word pack register: writes incoming bits LSB-first, tracks fill count.
module readback_packer
  import variable_table_readback_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          bit_valid_i,
  input  logic                          bit_i,
  output logic [WORD_WIDTH-1:0]         word_o,
  output logic [$clog2(WORD_WIDTH):0]   count_o,
  output logic                          full_o
);

  localparam int unsigned IW = $clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] word_q;
  logic [IW:0]           count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (bit_valid_i) begin
      word_q[count_q[IW-1:0]] <= bit_i;
      count_q                 <= count_q + (IW+1)'(1);
    end
  end

  assign word_o  = word_q;
  assign count_o = count_q;
  assign full_o  = (count_q == (IW+1)'(WORD_WIDTH));

endmodule

// File: rtl/variable_table_readback.sv
// Walks the variable table, packs assignment bits into words and streams them out.
// Optional READBACK_CHECKSUM_EN appends an XOR checksum word after the data words.
module variable_table_readback
  import variable_table_readback_pkg::*;
#(
  parameter int unsigned VARIABLE_ADDRESS_WIDTH = DEF_VARIABLE_ADDRESS_WIDTH,
  parameter int unsigned WORD_WIDTH             = DEF_WORD_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]   num_vars_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              tbl_en_o,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0] tbl_addr_o,
  input  logic                              tbl_data_i,
  output logic [WORD_WIDTH-1:0]             m_data_o,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic                              m_last_o
);

  localparam int unsigned AW = VARIABLE_ADDRESS_WIDTH;
  localparam int unsigned IW = $clog2(WORD_WIDTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [IW:0] WORD_BITS = (IW+1)'(WORD_WIDTH);
  localparam logic [IW:0] WORD_LAST = (IW+1)'(WORD_WIDTH-1);

  state_t state_q, state_d;

  // Counters are one bit wider than the address so a full table count never wraps.
  logic [AW:0] num_q, issue_q, cap_q;
  logic [IW:0] in_word_q;
  logic        pend_q;

  logic                  start_acc, issue, accept, data_done, last_word, final_cap;
  logic                  pk_clear, pk_full;
  logic [WORD_WIDTH-1:0] pk_word, out_word;
  logic [IW:0]           pk_count;

  assign start_acc = (state_q == IDLE) && start_i;
  assign issue     = (state_q == READ) && !pk_full && (in_word_q < WORD_BITS) && (issue_q < num_q);
  assign accept    = (state_q == OUT) && m_ready_i;
  assign data_done = (cap_q == num_q);
  assign final_cap = pend_q && ((pk_count == WORD_LAST) || ((cap_q + CNT_ONE) == num_q));
  assign pk_clear  = start_acc || (accept && !data_done);

  readback_packer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_packer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (pk_clear),
    .bit_valid_i(pend_q),
    .bit_i      (tbl_data_i),
    .word_o     (pk_word),
    .count_o    (pk_count),
    .full_o     (pk_full)
  );

`ifdef READBACK_CHECKSUM_EN
  logic                  csum_q;
  logic [WORD_WIDTH-1:0] xor_q;

  // csum_q marks that the data words are done and the checksum word is on the bus.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      csum_q <= 1'b0;
      xor_q  <= '0;
    end else if (start_acc) begin
      csum_q <= (num_vars_i == '0);
      xor_q  <= '0;
    end else if (state_q == FIN) begin
      csum_q <= 1'b0;
    end else if (accept && !csum_q) begin
      xor_q  <= xor_q ^ pk_word;
      csum_q <= data_done;
    end
  end

  assign last_word = csum_q;
  assign out_word  = csum_q ? xor_q : pk_word;
`else
  assign last_word = data_done;
  assign out_word  = pk_word;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      num_q     <= '0;
      issue_q   <= '0;
      cap_q     <= '0;
      in_word_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= issue;
      if (start_acc) begin
        num_q     <= num_vars_i;
        issue_q   <= '0;
        cap_q     <= '0;
        in_word_q <= '0;
      end else begin
        if (issue) begin
          issue_q   <= issue_q + CNT_ONE;
          in_word_q <= in_word_q + (IW+1)'(1);
        end
        if (pend_q) begin
          cap_q <= cap_q + CNT_ONE;
        end
        if (accept && !data_done) begin
          in_word_q <= '0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef READBACK_CHECKSUM_EN
          state_d = (num_vars_i == '0) ? OUT : READ;
`else
          state_d = (num_vars_i == '0) ? FIN : READ;
`endif
        end
      end
      READ: begin
        if (final_cap) state_d = OUT;
      end
      OUT: begin
        // With the checksum enabled, the last data word stays in OUT for the checksum word.
        if (accept) begin
          if (last_word)       state_d = FIN;
          else if (!data_done) state_d = READ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == READ) || (state_q == OUT);
  assign done_o     = (state_q == FIN);
  assign tbl_en_o   = issue;
  assign tbl_addr_o = issue ? issue_q[AW-1:0] : '0;
  assign m_valid_o  = (state_q == OUT);
  assign m_data_o   = m_valid_o ? out_word : '0;
  assign m_last_o   = m_valid_o && last_word;

endmodule

// File: tb/tb_variable_table_readback.sv
// Self-checking bench for variable_table_readback: table vectors plus reset corner case.
module tb_variable_table_readback;
  import variable_table_readback_pkg::*;

  localparam int unsigned AW    = 11;
  localparam int unsigned WW    = 32;
  localparam int unsigned DEPTH = 2048;
`ifdef READBACK_CHECKSUM_EN
  localparam int unsigned CSUM_WORDS = 1;
`else
  localparam int unsigned CSUM_WORDS = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW:0]   num_vars_i;
  logic          busy_o, done_o, tbl_en_o;
  logic [AW-1:0] tbl_addr_o;
  logic          tbl_data_i = 1'b0;
  logic [WW-1:0] m_data_o;
  logic          m_valid_o, m_ready_i, m_last_o;

  always #5 clk_i = ~clk_i;

  variable_table_readback #(
    .VARIABLE_ADDRESS_WIDTH(AW),
    .WORD_WIDTH            (WW)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .num_vars_i(num_vars_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .tbl_en_o  (tbl_en_o),
    .tbl_addr_o(tbl_addr_o),
    .tbl_data_i(tbl_data_i),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_last_o  (m_last_o)
  );

  logic tbl_mem [DEPTH];

  always @(posedge clk_i) begin
    if (tbl_en_o) tbl_data_i <= tbl_mem[tbl_addr_o];
  end

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int unsigned num;
    bit          stall;
    int unsigned words;
    int unsigned lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_expected(input int unsigned n);
    exp_t          e;
    logic [WW-1:0] x;
    int unsigned   nw;
    x  = '0;
    nw = word_count(n, WW);
    for (int unsigned w = 0; w < nw; w++) begin
      e.data = '0;
      for (int unsigned b = 0; b < WW; b++) begin
        if (w * WW + b < n) e.data[b] = tbl_mem[w * WW + b];
      end
      e.last = (w == nw - 1) && (CSUM_WORDS == 0);
      x = x ^ e.data;
      sb.push_back(e);
    end
    if (CSUM_WORDS != 0) begin
      e.data = x;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic run_case(input vec_t v);
    int unsigned   cyc, words, dones, done_cyc, wstall, rdn, last_addr;
    bit            seen_valid, prev_hold;
    logic [WW-1:0] pdata;
    logic          plast;
    exp_t          e;
    words = 0; dones = 0; done_cyc = 0; wstall = 0; rdn = 0; last_addr = 0;
    seen_valid = 1'b0; prev_hold = 1'b0; pdata = '0; plast = 1'b0;
    build_expected(v.num);
    @(negedge clk_i);
    num_vars_i = v.num[AW:0];
    start_i    = 1'b1;
    m_ready_i  = !v.stall;
    cyc = 0;
    while (cyc < 6000) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      // A second start mid-run must be ignored.
      start_i = (v.num == DEPTH) && (cyc == 100);
      if (start_i) num_vars_i = 12'd5;
      if (cyc == 1 && v.num != 0) check("busy_after_start", busy_o, 1);
      if (tbl_en_o) begin
        check("rd_addr", tbl_addr_o, rdn);
        rdn++;
        last_addr = tbl_addr_o;
      end
      if (done_o) begin
        dones++;
        if (dones == 1) done_cyc = cyc;
      end
      if (prev_hold) check("hold_valid", m_valid_o, 1);
      if (m_valid_o) begin
        check("no_read_in_out", tbl_en_o, 0);
        if (!seen_valid) begin
          seen_valid = 1'b1;
          if (v.num != 0) check("first_valid_cycle", cyc, v.lat);
        end
        if (prev_hold) begin
          check("hold_data", m_data_o, pdata);
          check("hold_last", m_last_o, plast);
        end
        if (v.stall && wstall < 5) begin
          m_ready_i = 1'b0;
          wstall++;
          prev_hold = 1'b1;
          pdata = m_data_o;
          plast = m_last_o;
        end else begin
          m_ready_i = 1'b1;
          prev_hold = 1'b0;
          wstall = 0;
          words++;
          if (sb.size() == 0) begin
            check("extra_word", 1, 0);
          end else begin
            e = sb.pop_front();
            check("word_data", m_data_o, e.data);
            check("word_last", m_last_o, e.last);
          end
        end
      end else begin
        m_ready_i = !v.stall;
        prev_hold = 1'b0;
      end
      if (dones > 0 && cyc >= done_cyc + 3) break;
    end
    if (dones == 0) check("timeout_done", 0, 1);
    check("done_count", dones, 1);
    check("word_count", words, v.words + CSUM_WORDS);
    check("scoreboard_empty", sb.size(), 0);
    check("busy_idle", busy_o, 0);
    if (v.num != 0) check("last_read_addr", last_addr, v.num - 1);
    if (v.num == 0 && CSUM_WORDS == 0) check("zero_done_fast", done_cyc <= 2, 1);
    sb.delete();
  endtask

  initial begin
    logic [31:0] pat;
    int unsigned k;
    pat = 32'hA5A5_F00F;
    for (int unsigned i = 0; i < DEPTH; i++) tbl_mem[i] = 1'($urandom_range(0, 1));
    for (int unsigned i = 0; i < 32; i++) tbl_mem[i] = pat[i];
    for (int unsigned i = 32; i < 40; i++) tbl_mem[i] = 1'b1;
    for (int unsigned i = 40; i < 64; i++) tbl_mem[i] = 1'b1;

    vecs[0] = '{num: 32,    stall: 1'b0, words: 1,  lat: 34};
    vecs[1] = '{num: 40,    stall: 1'b0, words: 2,  lat: 34};
    vecs[2] = '{num: 40,    stall: 1'b1, words: 2,  lat: 34};
    vecs[3] = '{num: 1,     stall: 1'b0, words: 1,  lat: 3};
    vecs[4] = '{num: 33,    stall: 1'b1, words: 2,  lat: 34};
    vecs[5] = '{num: 0,     stall: 1'b0, words: 0,  lat: 0};
    vecs[6] = '{num: DEPTH, stall: 1'b0, words: 64, lat: 34};

    rst_ni = 1'b0; start_i = 1'b0; num_vars_i = '0; m_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_tbl_en", tbl_en_o, 0);
    check("rst_tbl_addr", tbl_addr_o, 0);
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_m_last", m_last_o, 0);
    rst_ni = 1'b1;

    for (int unsigned i = 0; i < 7; i++) run_case(vecs[i]);

    // Reset while a word is waiting in OUT: everything drops, then a new run completes.
    @(negedge clk_i);
    num_vars_i = 12'd32;
    start_i    = 1'b1;
    m_ready_i  = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0;
    while (!m_valid_o && k < 100) begin
      @(posedge clk_i);
      @(negedge clk_i);
      k++;
    end
    check("reached_out", m_valid_o, 1);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_tbl_en", tbl_en_o, 0);
    check("midrst_m_valid", m_valid_o, 0);
    check("midrst_m_data", m_data_o, 0);
    check("midrst_m_last", m_last_o, 0);
    rst_ni = 1'b1;
    run_case(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/variable_table_readback.md
Name: variable_table_readback

Overview:
- Host-side result reader for the variable table: after a solve, it walks variable addresses 0..num_vars-1 through the table's single-bit read port.
- Captures each assignment bit and packs the bits LSB-first into WORD_WIDTH-bit words.
- Streams the words to the AXI/host side over a valid/ready interface.
- It is the read counterpart of the table's AXI write/load path; it sits between the variable table and the host DMA/AXI bridge.

Parameters:
- VARIABLE_ADDRESS_WIDTH, 11, width of a variable address; table depth is 2**VARIABLE_ADDRESS_WIDTH.
- WORD_WIDTH, 32, output word width; must be a power of two, at least 8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  one-cycle pulse starting a readback; ignored unless idle
- num_vars_i  in  VARIABLE_ADDRESS_WIDTH+1  number of variables to read; sampled on accepted start
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse when the last word has been accepted
- tbl_en_o  out  1  table read enable
- tbl_addr_o  out  VARIABLE_ADDRESS_WIDTH  table read address
- tbl_data_i  in  1  table read data; valid exactly 1 cycle after tbl_en_o
- m_data_o  out  WORD_WIDTH  packed assignment word
- m_valid_o  out  1  word valid
- m_ready_i  in  1  downstream ready
- m_last_o  out  1  marks the final word of the readback

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-operation drops any in-flight word without emitting done_o.
- States: IDLE, READ, OUT, FIN.
- IDLE:
  - start_i=1 latches num_vars_i and clears the pack register and counters.
  - If the latched count is 0: go to FIN (no words emitted).
  - Otherwise: go to READ.
- READ:
  - tbl_en_o=1 with tbl_addr_o = issue counter while issued-in-word < WORD_WIDTH and total issued < num_vars.
  - The issue counter increments per issue.
  - The bit returned the next cycle is written to pack[capture_idx mod WORD_WIDTH]; the capture counter increments.
  - When a word has WORD_WIDTH captured bits, or the final variable has been captured: go to OUT and assert m_valid_o the next cycle.
  - Unused high bits of a partial final word are 0.
- OUT:
  - m_data_o and m_last_o are held stable while m_valid_o=1 and m_ready_i=0.
  - No table reads occur in OUT.
  - On m_valid_o && m_ready_i:
    - If last: go to FIN.
    - Otherwise: clear the pack register and return to READ.
- FIN: done_o=1 for one cycle, busy_o deasserts, return to IDLE.
- start_i while busy_o=1 is ignored.
- m_valid_o must not depend combinationally on m_ready_i.
- Timing example, num_vars=32, WORD_WIDTH=32, start at cycle 0:
  - Reads issue on cycles 1..32.
  - Captures on cycles 2..33.
  - m_valid_o at cycle 34.
- Word count = ceil(num_vars/WORD_WIDTH).
- num_vars = 2**VARIABLE_ADDRESS_WIDTH reads the entire table; the address counter must not wrap before completion.

Optional Feature:
- Macro: READBACK_CHECKSUM_EN.
- Defined:
  - A running XOR of all emitted data words is kept.
  - After the last data word is accepted, one extra word carrying the XOR is emitted with m_last_o=1; data words then have m_last_o=0.
  - num_vars=0 emits a single checksum word of 0.
  - done_o follows acceptance of the checksum word.
- Undefined: no checksum logic; m_last_o is on the final data word.

Decomposition:
- Shared package:
  - State enum (IDLE/READ/OUT/FIN).
  - Default VARIABLE_ADDRESS_WIDTH and WORD_WIDTH constants.
  - Word-count helper function (ceil divide).
- One natural sub-module, readback_packer: bit-to-word shift/pack register with clear, bit index and full flag.
- The FSM and read-address counter stay in the top.

Test Plan:
- Preload table bits 0..31 = 0xA5A5_F00F (LSB = variable 0); start, num_vars=32, m_ready_i held 1 -> one word 0xA5A5F00F with m_last_o=1; m_valid_o first at cycle 34 after start; done_o pulses once.
- num_vars=40, table bits 32..39 = 0xFF -> two words: the first word, then 0x000000FF with m_last_o=1; padding bits are 0.
- Backpressure: m_ready_i toggled 0 for 5 cycles while m_valid_o=1 -> m_data_o/m_last_o stable; tbl_en_o=0 throughout the stall; no words lost or duplicated.
- num_vars=0 -> done_o within 2 cycles and no m_valid_o (with READBACK_CHECKSUM_EN: one word 0x0, m_last_o=1).
- num_vars=2048, full table -> 64 words matching the model; last read address 2047; no wrap; a start_i pulse mid-run is ignored.
- rst_ni=0 asserted during OUT -> next cycle all outputs 0, state IDLE; a subsequent start completes normally.
